pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Fetch-side and decode-side pipeline register controller that acts on the stall/kill requests raised by `hazard_detect`. It owns the PC, the IF/ID register and the hazard-relevant ID/EX fields. It holds, bubbles or flushes them per cycle, and feeds `hazard_detect` its inputs: `regIFID_*`, `regIDEX_rd`, `memReadIDEX`. It sits between instruction memory and the decode stage of the RV32I pipeline.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`)

- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `kill_IF`  in  1  from `hazard_detect`: hold PC and IF/ID
- `kill_DEC`  in  1  from `hazard_detect`: inject bubble into ID/EX
- `redirect`  in  1  taken branch/jump resolved in EX
- `redirect_pc`  in  32  target PC; bits [1:0] ignored, forced 0
- `imem_addr`  out  32  current PC, to instruction memory
- `imem_rdata`  in  32  instruction at `imem_addr`, combinational
- `imem_ack`  in  1  `imem_rdata` valid this cycle
- `ifid_pc`, `ifid_instr`  out  32 each  IF/ID register
- `ifid_valid`  out  1  IF/ID holds a real instruction
- `ifid_opcode`  out  7  `ifid_instr[6:0]`
- `ifid_rs1`, `ifid_rs2`, `ifid_rd`  out  5 each  `ifid_instr` [19:15], [24:20], [11:7]
- `idex_pc`, `idex_instr`  out  32 each  ID/EX register
- `idex_rd`  out  5  ID/EX destination
- `idex_mem_read`  out  1  ID/EX instruction is LOAD (opcode 7'b0000011)
- `idex_valid`  out  1  ID/EX holds a real instruction
- `stall_cnt`, `flush_cnt`  out  32 each  performance counters (see Configuration)

## Operation
- Per-cycle priority: reset > `redirect` > `kill_IF`/`kill_DEC` > `imem_ack` low > normal advance.
- Normal advance:
  - PC += 4.
  - IF/ID loads {PC, `imem_rdata`}, `ifid_valid` = 1.
  - ID/EX loads IF/ID contents; `idex_valid` takes `ifid_valid`.
- `redirect`:
  - PC = `redirect_pc`.
  - IF/ID and ID/EX both flushed to bubble: instr = `NOP_INSTR`, rd = 0, `idex_mem_read` = 0, valid = 0, pc retains old value.
  - Kills and ack are ignored that cycle.
- `kill_IF` and `kill_DEC` act independently:
  - `kill_IF`: PC and IF/ID hold.
  - `kill_DEC`: ID/EX loads bubble.
  - Load-use case (both asserted): PC/IF/ID hold and ID/EX bubbles, so the dependent instruction re-issues next cycle.
  - `kill_DEC` alone: IF/ID advances and the displaced IF/ID instruction is dropped. Avoiding this case is `hazard_detect`'s responsibility.
- `imem_ack` low (no kill, no redirect): PC holds, IF/ID loads bubble, ID/EX advances normally.
- `imem_ack` low with `kill_IF`: IF/ID holds; the held IF/ID is not bubbled.
- `idex_rd` and `idex_mem_read` are registered copies decoded from the IF/ID instruction at load time, never combinational from `idex_instr`.
- Bubble rule: whenever a register loads a bubble, its rd is forced to 0 and `idex_mem_read` to 0. This prevents false hazards downstream.

## Timing
- Reset (async assert, sync release):
  - PC = `RESET_PC`.
  - IF/ID and ID/EX = bubble, all valids 0, pcs = `RESET_PC`.
  - Counters = 0.
- Fetch-to-decode latency: 1 cycle (PC at edge N appears on `ifid_*` after edge N).
- IF/ID to ID/EX: 1 cycle.
- Redirect penalty: 2 bubbles. First real instruction from `redirect_pc` reaches IF/ID one edge after redirect, and ID/EX one edge later.
- `ifid_opcode/rs1/rs2/rd` are combinational slices of registered `ifid_instr`; `hazard_detect` reads them in the same cycle.
- PC wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- `rst_n` asserted mid-stall or mid-redirect: immediate return to reset values; no pending state survives.

## Configuration
- `PIPE_STALL_CNT_EN` defined:
  - `stall_cnt` increments each cycle `kill_IF` or `imem_ack` low holds the front end (redirect excluded).
  - `flush_cnt` increments each redirect cycle.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: both ports tied to 0; no counter flops synthesized.

## Structure
- Shared package `rv32i_pkg`: `NOP_INSTR` constant, opcode localparams (`OP_LOAD` = 7'b0000011, `OP_BRANCH` = 7'b1100011, `OP_IMM` = 7'b0010011), and field bit-range constants for rs1/rs2/rd.
- One sub-module: `sat_counter` (32-bit, enable, async active-low clear, saturating), instantiated twice under `PIPE_STALL_CNT_EN`.

## Test plan
- **Reset:** hold `rst_n`=0, then release with `imem_ack`=1, `imem_rdata`=32'h00200513.
  - During reset: `imem_addr`=0, `ifid_instr`=32'h00000013, `ifid_valid`=0, `idex_mem_read`=0.
  - After edge 1: `ifid_instr`=32'h00200513, `ifid_rd`=10.
- **Load-use:**
  - Feed lw x5,0(x10) (32'h00052283), then add x6,x5,x5 (32'h00528333).
  - After the lw reaches ID/EX, check `idex_rd`=5 and `idex_mem_read`=1.
  - Assert `kill_IF`=`kill_DEC`=1 for one cycle → PC held, `ifid_instr` stays 32'h00528333, ID/EX becomes bubble (`idex_rd`=0, `idex_valid`=0).
  - Next cycle the add reaches ID/EX.
- **Redirect:** `redirect`=1, `redirect_pc`=32'h40 at PC=0x10.
  - Next cycle: `imem_addr`=0x40, `ifid_valid`=0, `idex_valid`=0.
  - Two cycles later: `idex_pc`=0x40.
- **Redirect with kill:** `redirect`=1 together with `kill_IF`=`kill_DEC`=1 → redirect wins; PC=`redirect_pc`, both stages flushed.
- **Imem wait:** `imem_ack`=0 for 2 cycles at PC=0x8 → `imem_addr` stays 0x8, two bubbles enter IF/ID; with `PIPE_STALL_CNT_EN`, `stall_cnt`=2.
- **Reset mid-stall / wrap:**
  - Pulse `rst_n` low asynchronously while `kill_IF`=1 → all outputs return to reset values before the next edge.
  - Separately, with PC=0xFFFF_FFFC and no stall → next PC=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
//
// Shared RV32I definitions for the front-end pipeline control logic.
//
// Contents:
//   DEFAULT_RESET_PC  - default PC loaded on reset
//   NOP_INSTR         - bubble instruction (addi x0,x0,0)
//   OP_LOAD / OP_BRANCH / OP_IMM - opcode values used by hazard-related decode
//   *_MSB / *_LSB     - instruction field bit positions (opcode, rd, rs1, rs2)
//   fe_action_t       - per-cycle action of the PC + IF/ID register
//   be_action_t       - per-cycle action of the ID/EX register
//   instr_* helpers   - field extraction and opcode classification
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Opcode values the front end cares about.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    // addi x0,x0,0 expressed through its fields so it stays tied to OP_IMM.
    localparam logic [31:0] NOP_INSTR = {12'h000, 5'd0, 3'b000, 5'd0, OP_IMM};

    // Instruction field positions.
    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_LSB = 0;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 7;
    localparam int RS1_MSB    = 19;
    localparam int RS1_LSB    = 15;
    localparam int RS2_MSB    = 24;
    localparam int RS2_LSB    = 20;

    // What the PC and IF/ID register do this cycle.
    typedef enum logic [1:0] {
        FE_ADVANCE,   // PC += 4, IF/ID captures the fetched instruction
        FE_HOLD,      // PC and IF/ID keep their contents
        FE_BUBBLE,    // PC holds, IF/ID loads a bubble (fetch not acknowledged)
        FE_FLUSH      // PC takes the redirect target, IF/ID loads a bubble
    } fe_action_t;

    // What the ID/EX register does this cycle.
    typedef enum logic [1:0] {
        BE_ADVANCE,   // ID/EX captures the IF/ID contents
        BE_BUBBLE,    // ID/EX loads a bubble (decode killed)
        BE_FLUSH      // ID/EX loads a bubble (redirect)
    } be_action_t;

    function automatic logic [6:0] instr_opcode(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [4:0] instr_rd(input logic [31:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [4:0] instr_rs1(input logic [31:0] instr);
        return instr[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [4:0] instr_rs2(input logic [31:0] instr);
        return instr[RS2_MSB:RS2_LSB];
    endfunction

    function automatic logic is_load(input logic [31:0] instr);
        return instr_opcode(instr) == OP_LOAD;
    endfunction

    function automatic logic is_branch(input logic [31:0] instr);
        return instr_opcode(instr) == OP_BRANCH;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//
// Saturating up-counter with enable and asynchronous active-low clear.
// The count sticks at all-ones instead of wrapping back to zero.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low clear
//   en     in   1      increment this cycle
//   count  out  WIDTH  current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic at_max;

    assign at_max = &count;

    // Count up on enable, hold once the counter is saturated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && !at_max) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Front-end pipeline register controller for the RV32I core. Owns the PC,
// the IF/ID register and the hazard-relevant part of the ID/EX register, and
// holds, bubbles or flushes them each cycle according to the stall/kill
// requests from hazard_detect, taken redirects from EX and instruction
// memory acknowledge.
//
// Per-cycle priority: reset > redirect > kill_IF/kill_DEC > imem_ack low >
// normal advance. kill_IF controls the PC + IF/ID side, kill_DEC the ID/EX
// side; they act independently.
//
// Optional feature: define PIPE_STALL_CNT_EN to build saturating stall and
// flush performance counters. Without it, stall_cnt/flush_cnt read as zero
// and no counter flops exist.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   kill_IF, kill_DEC     hold PC + IF/ID / bubble ID/EX (from hazard_detect)
//   redirect, redirect_pc taken branch/jump from EX and its target
//   imem_addr             current PC to instruction memory
//   imem_rdata, imem_ack  fetched instruction and its valid strobe
//   ifid_*                IF/ID register and its combinational field slices
//   idex_*                ID/EX register, registered rd and load flag
//   stall_cnt, flush_cnt  performance counters
// ---------------------------------------------------------------------------
module pipe_stall_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kill_IF,
    input  logic        kill_DEC,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic [6:0]  ifid_opcode,
    output logic [4:0]  ifid_rs1,
    output logic [4:0]  ifid_rs2,
    output logic [4:0]  ifid_rd,
    output logic [31:0] idex_pc,
    output logic [31:0] idex_instr,
    output logic [4:0]  idex_rd,
    output logic        idex_mem_read,
    output logic        idex_valid,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    fe_action_t  fe_action;
    be_action_t  be_action;

    logic [31:0] pc;
    logic [31:0] redirect_target;
    logic        unused_redirect_lsbs;

    // Redirect targets are word aligned; the low two bits are dropped.
    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Resolve the per-cycle priority into one action for each half of the
    // front end. A redirect overrides everything below reset, so both
    // halves flush together. Otherwise the fetch side and the decode side
    // are decided separately: kill_IF holds fetch (and masks a missing ack,
    // so a held IF/ID instruction is never bubbled away), kill_DEC bubbles
    // ID/EX no matter what the fetch side does.
    always_comb begin
        fe_action = FE_ADVANCE;
        be_action = BE_ADVANCE;
        if (redirect) begin
            fe_action = FE_FLUSH;
            be_action = BE_FLUSH;
        end else begin
            if (kill_IF) begin
                fe_action = FE_HOLD;
            end else if (!imem_ack) begin
                fe_action = FE_BUBBLE;
            end
            if (kill_DEC) begin
                be_action = BE_BUBBLE;
            end
        end
    end

    // PC and IF/ID register. A bubble keeps the old ifid_pc; only the
    // instruction and valid bit change. PC arithmetic is 32-bit so it
    // wraps from 0xFFFF_FFFC to 0 on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            ifid_pc    <= RESET_PC;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else begin
            unique case (fe_action)
                FE_ADVANCE: begin
                    pc         <= pc + 32'd4;
                    ifid_pc    <= pc;
                    ifid_instr <= imem_rdata;
                    ifid_valid <= 1'b1;
                end
                FE_HOLD: begin
                    pc         <= pc;
                    ifid_instr <= ifid_instr;
                    ifid_valid <= ifid_valid;
                end
                FE_BUBBLE: begin
                    ifid_instr <= NOP_INSTR;
                    ifid_valid <= 1'b0;
                end
                FE_FLUSH: begin
                    pc         <= redirect_target;
                    ifid_instr <= NOP_INSTR;
                    ifid_valid <= 1'b0;
                end
                default: begin
                    pc <= pc;
                end
            endcase
        end
    end

    // ID/EX register. rd and the load flag are decoded from the IF/ID
    // instruction as it is captured, so hazard_detect sees a flop output
    // instead of a decode path hanging off idex_instr. An invalid IF/ID
    // entry is gated so it can never look like a real destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_pc       <= RESET_PC;
            idex_instr    <= NOP_INSTR;
            idex_rd       <= 5'd0;
            idex_mem_read <= 1'b0;
            idex_valid    <= 1'b0;
        end else begin
            unique case (be_action)
                BE_ADVANCE: begin
                    idex_pc       <= ifid_pc;
                    idex_instr    <= ifid_instr;
                    idex_rd       <= ifid_valid ? instr_rd(ifid_instr) : 5'd0;
                    idex_mem_read <= ifid_valid && is_load(ifid_instr);
                    idex_valid    <= ifid_valid;
                end
                BE_BUBBLE, BE_FLUSH: begin
                    idex_instr    <= NOP_INSTR;
                    idex_rd       <= 5'd0;
                    idex_mem_read <= 1'b0;
                    idex_valid    <= 1'b0;
                end
                default: begin
                    idex_valid <= idex_valid;
                end
            endcase
        end
    end

    // hazard_detect compares these against ID/EX in the same cycle, so they
    // are plain slices of the registered IF/ID instruction.
    assign imem_addr   = pc;
    assign ifid_opcode = instr_opcode(ifid_instr);
    assign ifid_rs1    = instr_rs1(ifid_instr);
    assign ifid_rs2    = instr_rs2(ifid_instr);
    assign ifid_rd     = instr_rd(ifid_instr);

`ifdef PIPE_STALL_CNT_EN
    // A stall cycle is any non-redirect cycle in which the PC does not move
    // forward: either hazard_detect held fetch or memory did not answer.
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = (fe_action == FE_HOLD) || (fe_action == FE_BUBBLE);
    assign flush_inc = (fe_action == FE_FLUSH);

    sat_counter #(
        .WIDTH (32)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (32)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flush_inc),
        .count (flush_cnt)
    );
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
//
// Self-checking bench for pipe_stall_ctrl. Every accepted fetch pushes its
// expected {pc, instr} onto a scoreboard queue; the entry is popped and
// compared once the instruction shows up in IF/ID. ID/EX contents are
// checked against what IF/ID held one cycle earlier.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

`ifdef PIPE_STALL_CNT_EN
    localparam logic CNT_EN = 1'b1;
`else
    localparam logic CNT_EN = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] LW  = 32'h0005_2283;
    localparam logic [31:0] ADD = 32'h0052_8333;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        kill_IF;
    logic        kill_DEC;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [6:0]  ifid_opcode;
    logic [4:0]  ifid_rs1;
    logic [4:0]  ifid_rs2;
    logic [4:0]  ifid_rd;
    logic [31:0] idex_pc;
    logic [31:0] idex_instr;
    logic [4:0]  idex_rd;
    logic        idex_mem_read;
    logic        idex_valid;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    exp_t        ifid_q[$];
    logic [31:0] exp_pc;
    int          n_checks = 0;
    int          n_pass   = 0;

    pipe_stall_ctrl #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .kill_IF       (kill_IF),
        .kill_DEC      (kill_DEC),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid),
        .ifid_opcode   (ifid_opcode),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .ifid_rd       (ifid_rd),
        .idex_pc       (idex_pc),
        .idex_instr    (idex_instr),
        .idex_rd       (idex_rd),
        .idex_mem_read (idex_mem_read),
        .idex_valid    (idex_valid),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction that will be accepted this cycle.
    task automatic fetch(input logic [31:0] instr);
        exp_t e;
        imem_ack   = 1'b1;
        imem_rdata = instr;
        e.pc       = exp_pc;
        e.instr    = instr;
        e.valid    = 1'b1;
        ifid_q.push_back(e);
        exp_pc     = exp_pc + 32'd4;
    endtask

    function automatic exp_t pop_ifid();
        exp_t e;
        e = '0;
        if (ifid_q.size() != 0) e = ifid_q.pop_front();
        return e;
    endfunction

    task automatic do_reset();
        rst_n       = 1'b0;
        kill_IF     = 1'b0;
        kill_DEC    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b1;
        imem_rdata  = NOP;
        ifid_q.delete();
        exp_pc      = 32'h0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n       = 1'b0;
        kill_IF     = 1'b0;
        kill_DEC    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b1;
        imem_rdata  = 32'h0020_0513;
        exp_pc      = 32'h0;
        repeat (2) step();
        n_checks++; if (imem_addr !== 32'h0) $display("[TB] FAIL rst_addr: got %h want %h", imem_addr, 32'h0); else n_pass++;
        n_checks++; if (ifid_instr !== NOP) $display("[TB] FAIL rst_ifid_instr: got %h want %h", ifid_instr, NOP); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0) $display("[TB] FAIL rst_ifid_valid: got %b want 0", ifid_valid); else n_pass++;
        n_checks++; if (idex_mem_read !== 1'b0) $display("[TB] FAIL rst_mem_read: got %b want 0", idex_mem_read); else n_pass++;
        n_checks++; if (idex_valid !== 1'b0) $display("[TB] FAIL rst_idex_valid: got %b want 0", idex_valid); else n_pass++;
        n_checks++; if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) $display("[TB] FAIL rst_cnt: got %h/%h want 0/0", stall_cnt, flush_cnt); else n_pass++;
        rst_n = 1'b1;
        fetch(32'h0020_0513);
        step();
        e = pop_ifid();
        n_checks++; if (ifid_instr !== e.instr) $display("[TB] FAIL first_instr: got %h want %h", ifid_instr, e.instr); else n_pass++;
        n_checks++; if (ifid_pc !== e.pc) $display("[TB] FAIL first_pc: got %h want %h", ifid_pc, e.pc); else n_pass++;
        n_checks++; if (ifid_rd !== 5'd10) $display("[TB] FAIL first_rd: got %0d want 10", ifid_rd); else n_pass++;
        n_checks++; if (ifid_opcode !== 7'h13) $display("[TB] FAIL first_opcode: got %h want 13", ifid_opcode); else n_pass++;
        n_checks++; if (imem_addr !== exp_pc) $display("[TB] FAIL first_next_pc: got %h want %h", imem_addr, exp_pc); else n_pass++;
    endtask

    task automatic test_load_use();
        exp_t e;
        fetch(LW);
        step();
        e = pop_ifid();
        n_checks++; if (ifid_instr !== e.instr || ifid_pc !== e.pc) $display("[TB] FAIL lu_lw_ifid: got %h@%h want %h@%h", ifid_instr, ifid_pc, e.instr, e.pc); else n_pass++;
        fetch(ADD);
        step();
        e = pop_ifid();
        n_checks++; if (ifid_instr !== e.instr || ifid_pc !== e.pc) $display("[TB] FAIL lu_add_ifid: got %h@%h want %h@%h", ifid_instr, ifid_pc, e.instr, e.pc); else n_pass++;
        n_checks++; if (ifid_rs1 !== 5'd5 || ifid_rs2 !== 5'd5) $display("[TB] FAIL lu_add_rs: got %0d,%0d want 5,5", ifid_rs1, ifid_rs2); else n_pass++;
        n_checks++; if (idex_rd !== 5'd5) $display("[TB] FAIL lu_idex_rd: got %0d want 5", idex_rd); else n_pass++;
        n_checks++; if (idex_mem_read !== 1'b1) $display("[TB] FAIL lu_mem_read: got %b want 1", idex_mem_read); else n_pass++;
        n_checks++; if (idex_instr !== LW) $display("[TB] FAIL lu_idex_instr: got %h want %h", idex_instr, LW); else n_pass++;
        // Load-use stall: both kills for one cycle.
        kill_IF    = 1'b1;
        kill_DEC   = 1'b1;
        imem_rdata = 32'h0010_0093;
        step();
        n_checks++; if (imem_addr !== exp_pc) $display("[TB] FAIL lu_pc_hold: got %h want %h", imem_addr, exp_pc); else n_pass++;
        n_checks++; if (ifid_instr !== ADD || ifid_valid !== 1'b1) $display("[TB] FAIL lu_ifid_hold: got %h/%b want %h/1", ifid_instr, ifid_valid, ADD); else n_pass++;
        n_checks++; if (idex_rd !== 5'd0 || idex_valid !== 1'b0) $display("[TB] FAIL lu_bubble: got rd %0d valid %b want 0/0", idex_rd, idex_valid); else n_pass++;
        n_checks++; if (idex_mem_read !== 1'b0 || idex_instr !== NOP) $display("[TB] FAIL lu_bubble_instr: got %h/%b want %h/0", idex_instr, idex_mem_read, NOP); else n_pass++;
        kill_IF  = 1'b0;
        kill_DEC = 1'b0;
        fetch(32'h0010_0093);
        step();
        e = pop_ifid();
        n_checks++; if (ifid_instr !== e.instr || ifid_pc !== e.pc) $display("[TB] FAIL lu_next_ifid: got %h@%h want %h@%h", ifid_instr, ifid_pc, e.instr, e.pc); else n_pass++;
        n_checks++; if (idex_instr !== ADD || idex_rd !== 5'd6) $display("[TB] FAIL lu_reissue: got %h rd %0d want %h rd 6", idex_instr, idex_rd, ADD); else n_pass++;
        n_checks++; if (idex_valid !== 1'b1 || idex_mem_read !== 1'b0) $display("[TB] FAIL lu_reissue_flags: got %b/%b want 1/0", idex_valid, idex_mem_read); else n_pass++;
        n_checks++; if (stall_cnt !== {31'd0, CNT_EN}) $display("[TB] FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, CNT_EN); else n_pass++;
    endtask

    task automatic test_redirect();
        exp_t e;
        n_checks++; if (imem_addr !== 32'h10) $display("[TB] FAIL rd_start_pc: got %h want 10", imem_addr); else n_pass++;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        imem_rdata  = 32'h0030_0113;
        step();
        redirect = 1'b0;
        exp_pc   = 32'h40;
        n_checks++; if (imem_addr !== 32'h40) $display("[TB] FAIL rd_pc: got %h want 40", imem_addr); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0 || idex_valid !== 1'b0) $display("[TB] FAIL rd_valids: got %b/%b want 0/0", ifid_valid, idex_valid); else n_pass++;
        n_checks++; if (ifid_instr !== NOP || idex_rd !== 5'd0) $display("[TB] FAIL rd_bubble: got %h rd %0d want %h rd 0", ifid_instr, idex_rd, NOP); else n_pass++;
        n_checks++; if (flush_cnt !== {31'd0, CNT_EN}) $display("[TB] FAIL rd_flush_cnt: got %0d want %0d", flush_cnt, CNT_EN); else n_pass++;
        fetch(32'h0040_0193);
        step();
        e = pop_ifid();
        n_checks++; if (ifid_instr !== e.instr || ifid_pc !== e.pc) $display("[TB] FAIL rd_target_ifid: got %h@%h want %h@%h", ifid_instr, ifid_pc, e.instr, e.pc); else n_pass++;
        n_checks++; if (idex_valid !== 1'b0) $display("[TB] FAIL rd_second_bubble: got %b want 0", idex_valid); else n_pass++;
        fetch(32'h0000_2203);
        step();
        e = pop_ifid();
        n_checks++; if (ifid_instr !== e.instr || ifid_pc !== e.pc) $display("[TB] FAIL rd_b_ifid: got %h@%h want %h@%h", ifid_instr, ifid_pc, e.instr, e.pc); else n_pass++;
        n_checks++; if (idex_pc !== 32'h40 || idex_valid !== 1'b1) $display("[TB] FAIL rd_idex_pc: got %h/%b want 40/1", idex_pc, idex_valid); else n_pass++;
        n_checks++; if (idex_rd !== 5'd3) $display("[TB] FAIL rd_idex_rd: got %0d want 3", idex_rd); else n_pass++;
    endtask

    task automatic test_redirect_kill();
        redirect    = 1'b1;
        kill_IF     = 1'b1;
        kill_DEC    = 1'b1;
        imem_ack    = 1'b0;
        redirect_pc = 32'h0000_0102;
        step();
        redirect = 1'b0;
        kill_IF  = 1'b0;
        kill_DEC = 1'b0;
        imem_ack = 1'b1;
        exp_pc   = 32'h100;
        n_checks++; if (imem_addr !== 32'h100) $display("[TB] FAIL rk_pc: got %h want 100", imem_addr); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) $display("[TB] FAIL rk_ifid: got %h/%b want %h/0", ifid_instr, ifid_valid, NOP); else n_pass++;
        n_checks++; if (ifid_pc !== 32'h44) $display("[TB] FAIL rk_ifid_pc: got %h want 44", ifid_pc); else n_pass++;
        n_checks++; if (idex_valid !== 1'b0 || idex_mem_read !== 1'b0 || idex_rd !== 5'd0) $display("[TB] FAIL rk_idex: got %b/%b/%0d want 0/0/0", idex_valid, idex_mem_read, idex_rd); else n_pass++;
        n_checks++; if (stall_cnt !== {31'd0, CNT_EN}) $display("[TB] FAIL rk_stall_cnt: got %0d want %0d", stall_cnt, CNT_EN); else n_pass++;
        n_checks++; if (flush_cnt !== {30'd0, CNT_EN, 1'b0}) $display("[TB] FAIL rk_flush_cnt: got %0d want %0d", flush_cnt, {CNT_EN, 1'b0}); else n_pass++;
    endtask

    task automatic test_imem_wait();
        exp_t e;
        do_reset();
        fetch(32'h0050_0293);
        step();
        e = pop_ifid();
        n_checks++; if (ifid_instr !== e.instr || ifid_pc !== e.pc) $display("[TB] FAIL iw_i0: got %h@%h want %h@%h", ifid_instr, ifid_pc, e.instr, e.pc); else n_pass++;
        fetch(32'h0060_0313);
        step();
        e = pop_ifid();
        n_checks++; if (ifid_instr !== e.instr || ifid_pc !== e.pc) $display("[TB] FAIL iw_i1: got %h@%h want %h@%h", ifid_instr, ifid_pc, e.instr, e.pc); else n_pass++;
        imem_ack   = 1'b0;
        imem_rdata = 32'hFFFF_FFFF;
        step();
        n_checks++; if (imem_addr !== 32'h8) $display("[TB] FAIL iw_pc1: got %h want 8", imem_addr); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP || ifid_rd !== 5'd0) $display("[TB] FAIL iw_bubble1: got %h/%b want %h/0", ifid_instr, ifid_valid, NOP); else n_pass++;
        n_checks++; if (idex_instr !== 32'h0060_0313 || idex_valid !== 1'b1) $display("[TB] FAIL iw_idex_adv: got %h/%b want 00600313/1", idex_instr, idex_valid); else n_pass++;
        step();
        n_checks++; if (imem_addr !== 32'h8) $display("[TB] FAIL iw_pc2: got %h want 8", imem_addr); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0 || idex_valid !== 1'b0 || idex_rd !== 5'd0) $display("[TB] FAIL iw_bubble2: got %b/%b rd %0d want 0/0 rd 0", ifid_valid, idex_valid, idex_rd); else n_pass++;
        n_checks++; if (stall_cnt !== {30'd0, CNT_EN, 1'b0}) $display("[TB] FAIL iw_stall_cnt: got %0d want %0d", stall_cnt, {CNT_EN, 1'b0}); else n_pass++;
        fetch(32'h0070_0393);
        step();
        e = pop_ifid();
        n_checks++; if (ifid_instr !== e.instr || ifid_pc !== e.pc) $display("[TB] FAIL iw_resume: got %h@%h want %h@%h", ifid_instr, ifid_pc, e.instr, e.pc); else n_pass++;
        n_checks++; if (imem_addr !== exp_pc) $display("[TB] FAIL iw_resume_pc: got %h want %h", imem_addr, exp_pc); else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        kill_IF = 1'b1;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (imem_addr !== 32'h0) $display("[TB] FAIL rms_pc: got %h want 0", imem_addr); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP || ifid_pc !== 32'h0) $display("[TB] FAIL rms_ifid: got %h@%h/%b want %h@0/0", ifid_instr, ifid_pc, ifid_valid, NOP); else n_pass++;
        n_checks++; if (idex_valid !== 1'b0 || idex_pc !== 32'h0 || idex_rd !== 5'd0) $display("[TB] FAIL rms_idex: got %h/%b rd %0d want 0/0 rd 0", idex_pc, idex_valid, idex_rd); else n_pass++;
        n_checks++; if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) $display("[TB] FAIL rms_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); else n_pass++;
        kill_IF = 1'b0;
        step();
        rst_n  = 1'b1;
        exp_pc = 32'h0;
        ifid_q.delete();
    endtask

    task automatic test_wrap();
        exp_t e;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        exp_pc   = 32'hFFFF_FFFC;
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_start: got %h want fffffffc", imem_addr); else n_pass++;
        fetch(32'h0080_0413);
        step();
        e = pop_ifid();
        n_checks++; if (ifid_pc !== e.pc || ifid_instr !== e.instr) $display("[TB] FAIL wrap_ifid: got %h@%h want %h@%h", ifid_instr, ifid_pc, e.instr, e.pc); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0) $display("[TB] FAIL wrap_pc: got %h want 0", imem_addr); else n_pass++;
    endtask

    // Random accepted/unacknowledged fetches with a mix of loads, checked
    // through the scoreboard and a one-deep model of the IF/ID contents.
    task automatic test_back_to_back();
        exp_t        cur;
        exp_t        prev;
        exp_t        e;
        logic        ack;
        logic [31:0] instr;
        cur.pc    = 32'hFFFF_FFFC;
        cur.instr = 32'h0080_0413;
        cur.valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            ack   = ($urandom_range(0, 3) != 0);
            instr = $urandom;
            if ($urandom_range(0, 2) == 0) instr[6:0] = 7'b0000011;
            if (ack) begin
                fetch(instr);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = instr;
            end
            prev = cur;
            step();
            if (ack) begin
                n_checks++;
                if (ifid_q.size() == 0) begin
                    $display("[TB] FAIL b2b_queue: got empty want entry");
                end else begin
                    e = pop_ifid();
                    if (ifid_pc !== e.pc || ifid_instr !== e.instr || ifid_valid !== 1'b1 || ifid_rd !== e.instr[11:7])
                        $display("[TB] FAIL b2b_ifid: got %h@%h/%b want %h@%h/1", ifid_instr, ifid_pc, ifid_valid, e.instr, e.pc);
                    else n_pass++;
                    cur = e;
                end
            end else begin
                n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) $display("[TB] FAIL b2b_ifid_bubble: got %h/%b want %h/0", ifid_instr, ifid_valid, NOP); else n_pass++;
                cur.instr = NOP;
                cur.valid = 1'b0;
            end
            n_checks++; if (imem_addr !== exp_pc) $display("[TB] FAIL b2b_pc: got %h want %h", imem_addr, exp_pc); else n_pass++;
            n_checks++;
            if (prev.valid) begin
                if (idex_valid !== 1'b1 || idex_pc !== prev.pc || idex_instr !== prev.instr || idex_rd !== prev.instr[11:7] || idex_mem_read !== (prev.instr[6:0] == 7'b0000011))
                    $display("[TB] FAIL b2b_idex: got %h@%h rd %0d ld %b want %h@%h rd %0d", idex_instr, idex_pc, idex_rd, idex_mem_read, prev.instr, prev.pc, prev.instr[11:7]);
                else n_pass++;
            end else begin
                if (idex_valid !== 1'b0 || idex_rd !== 5'd0 || idex_mem_read !== 1'b0)
                    $display("[TB] FAIL b2b_idex_bubble: got %b rd %0d ld %b want 0 rd 0 ld 0", idex_valid, idex_rd, idex_mem_read);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_redirect_kill();
        test_imem_wait();
        test_reset_mid_stall();
        test_wrap();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
